// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multicycle RV64I control FSM sequencing fetch/decode/execute with halt and retire counting
module controle_multiciclo #(
  parameter int MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] INSTR,
  input  logic        AluZero,
  output logic        PCwrite,
  output logic        PCWriteCond,
  output logic        MemRead,
  output logic        LoadIR,
  output logic        SelMux2,
  output logic [1:0]  SelMux4,
  output logic        SelMuxPC,
  output logic        SelMuxMem,
  output logic [2:0]  AluOperation,
  output logic        RegWrite,
  output logic        loadRegA,
  output logic        loadRegB,
  output logic        loadRegAluOut,
  output logic        loadRegMemData,
  output logic        MemData_Read,
  output logic        exitState,
  output logic        illegal_instr,
  output logic [31:0] instr_count
);
  typedef enum logic [3:0] {
    RST_ST, FETCH, IR_LOAD, DECODE, EXEC_R, EXEC_I, LD_ADDR,
    LD_CAP, LD_WB, SD_WR, BRANCH, NEXT_PC, HALT
  } state_t;
  localparam int WW = MEM_WAIT > 1 ? $clog2(MEM_WAIT) : 1;
  localparam logic [WW-1:0] WLAST = WW'(MEM_WAIT - 1);
  state_t state_q, state_d, dec_st;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [31:0] cnt_q, cnt_d;
  logic illegal_q, illegal_d;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic wait_done, taken, is_break, retire;
  logic unused_bits;
  assign op = INSTR[6:0];
  assign f3 = INSTR[14:12];
  assign f7 = INSTR[31:25];
  assign unused_bits = ^{INSTR[24:15], INSTR[11:7]};
  assign wait_done = wcnt_q == WLAST;
  assign is_break = op == 7'b1110011;
  // beq is the only branch encoding with opcode 1100011; everything else reaching BRANCH is bne
  assign taken = (op == 7'b1100011) ? AluZero : !AluZero;
  assign retire = state_q == NEXT_PC || (state_q == BRANCH && taken);
  assign dec_st = (op == 7'b0110011 && f3 == 3'b000 && (f7 == 7'b0000000 || f7 == 7'b0100000)) ? EXEC_R :
                  (op == 7'b0010011 && f3 == 3'b000) ? EXEC_I :
                  (op == 7'b0000011 && f3 == 3'b011) ? LD_ADDR :
                  (op == 7'b0100011 && f3 == 3'b111) ? SD_WR :
                  (op == 7'b1100011 && f3 == 3'b000) ? BRANCH :
                  (op == 7'b1100111 && f3 == 3'b001) ? BRANCH : HALT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RST_ST;
      wcnt_q    <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end
  always_comb begin
    case (state_q)
      RST_ST:  state_d = FETCH;
      FETCH:   state_d = wait_done ? IR_LOAD : FETCH;
      IR_LOAD: state_d = DECODE;
      DECODE:  state_d = dec_st;
      EXEC_R:  state_d = NEXT_PC;
      EXEC_I:  state_d = NEXT_PC;
      LD_ADDR: state_d = wait_done ? LD_CAP : LD_ADDR;
      LD_CAP:  state_d = LD_WB;
      LD_WB:   state_d = NEXT_PC;
      SD_WR:   state_d = NEXT_PC;
      BRANCH:  state_d = taken ? FETCH : NEXT_PC;
      NEXT_PC: state_d = FETCH;
      default: state_d = HALT;
    endcase
    wcnt_d    = (state_d != state_q) ? '0 : wcnt_q + WW'(1);
    cnt_d     = cnt_q + (retire ? 32'd1 : 32'd0);
    illegal_d = (state_q == DECODE) ? (dec_st == HALT && !is_break) : illegal_q;
  end
  always_comb begin
    PCwrite        = 1'b0;
    PCWriteCond    = 1'b0;
    MemRead        = 1'b0;
    LoadIR         = 1'b0;
    SelMux2        = 1'b0;
    SelMux4        = 2'b00;
    SelMuxPC       = 1'b0;
    SelMuxMem      = 1'b0;
    AluOperation   = 3'b000;
    RegWrite       = 1'b0;
    loadRegA       = 1'b0;
    loadRegB       = 1'b0;
    loadRegAluOut  = 1'b0;
    loadRegMemData = 1'b0;
    MemData_Read   = 1'b0;
    exitState      = 1'b0;
    illegal_instr  = 1'b0;
    instr_count    = cnt_q;
    case (state_q)
      FETCH:   MemRead = 1'b1;
      IR_LOAD: begin
        MemRead = 1'b1;
        LoadIR  = 1'b1;
      end
      DECODE: begin
        loadRegA      = 1'b1;
        loadRegB      = 1'b1;
        SelMux4       = 2'b11;
        AluOperation  = 3'b001;
        loadRegAluOut = 1'b1;
      end
      EXEC_R: begin
        SelMux2      = 1'b1;
        AluOperation = (f7 == 7'b0100000) ? 3'b010 : 3'b001;
        RegWrite     = 1'b1;
      end
      EXEC_I: begin
        SelMux2      = 1'b1;
        SelMux4      = 2'b10;
        AluOperation = 3'b001;
        RegWrite     = 1'b1;
      end
      LD_ADDR, LD_CAP: begin
        SelMux2        = 1'b1;
        SelMux4        = 2'b10;
        AluOperation   = 3'b001;
        loadRegMemData = state_q == LD_CAP;
      end
      LD_WB: begin
        RegWrite  = 1'b1;
        SelMuxMem = 1'b1;
      end
      SD_WR: begin
        SelMux2      = 1'b1;
        SelMux4      = 2'b10;
        AluOperation = 3'b001;
        MemData_Read = 1'b1;
      end
      BRANCH: begin
        SelMux2      = 1'b1;
        AluOperation = 3'b010;
        PCWriteCond  = 1'b1;
        PCwrite      = taken;
        SelMuxPC     = taken;
      end
      NEXT_PC: begin
        SelMux4      = 2'b01;
        AluOperation = 3'b001;
        PCwrite      = 1'b1;
      end
      HALT: begin
        exitState     = 1'b1;
        illegal_instr = illegal_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_controle_multiciclo.sv
// tb_controle_multiciclo: per-cycle vector table plus hand-written branch/reset sequences
module tb_controle_multiciclo;
  localparam int W = 2;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] INSTR;
  logic AluZero;
  logic PCwrite, PCWriteCond, MemRead, LoadIR, SelMux2, SelMuxPC, SelMuxMem;
  logic [1:0] SelMux4;
  logic [2:0] AluOperation;
  logic RegWrite, loadRegA, loadRegB, loadRegAluOut, loadRegMemData, MemData_Read;
  logic exitState, illegal_instr;
  logic [31:0] instr_count;
  logic [19:0] ctl;
  always #5 clk = ~clk;
  controle_multiciclo #(.MEM_WAIT(W)) dut (
    .clk(clk), .rst(rst), .INSTR(INSTR), .AluZero(AluZero),
    .PCwrite(PCwrite), .PCWriteCond(PCWriteCond), .MemRead(MemRead), .LoadIR(LoadIR),
    .SelMux2(SelMux2), .SelMux4(SelMux4), .SelMuxPC(SelMuxPC), .SelMuxMem(SelMuxMem),
    .AluOperation(AluOperation), .RegWrite(RegWrite), .loadRegA(loadRegA), .loadRegB(loadRegB),
    .loadRegAluOut(loadRegAluOut), .loadRegMemData(loadRegMemData), .MemData_Read(MemData_Read),
    .exitState(exitState), .illegal_instr(illegal_instr), .instr_count(instr_count)
  );
  assign ctl = {PCwrite, PCWriteCond, MemRead, LoadIR, SelMux2, SelMux4, SelMuxPC, SelMuxMem,
                AluOperation, RegWrite, loadRegA, loadRegB, loadRegAluOut, loadRegMemData,
                MemData_Read, exitState, illegal_instr};
  // PCw PCWC MR LIR S2 S4 SPC SMem ALU RW lA lB lAO lMD MDR ex ill
  localparam logic [19:0] E_RST  = 20'b0_0_0_0_0_00_0_0_000_0_0_0_0_0_0_0_0;
  localparam logic [19:0] E_FET  = 20'b0_0_1_0_0_00_0_0_000_0_0_0_0_0_0_0_0;
  localparam logic [19:0] E_IR   = 20'b0_0_1_1_0_00_0_0_000_0_0_0_0_0_0_0_0;
  localparam logic [19:0] E_DEC  = 20'b0_0_0_0_0_11_0_0_001_0_1_1_1_0_0_0_0;
  localparam logic [19:0] E_ADD  = 20'b0_0_0_0_1_00_0_0_001_1_0_0_0_0_0_0_0;
  localparam logic [19:0] E_SUB  = 20'b0_0_0_0_1_00_0_0_010_1_0_0_0_0_0_0_0;
  localparam logic [19:0] E_ADDI = 20'b0_0_0_0_1_10_0_0_001_1_0_0_0_0_0_0_0;
  localparam logic [19:0] E_LDA  = 20'b0_0_0_0_1_10_0_0_001_0_0_0_0_0_0_0_0;
  localparam logic [19:0] E_LDC  = 20'b0_0_0_0_1_10_0_0_001_0_0_0_0_1_0_0_0;
  localparam logic [19:0] E_LDW  = 20'b0_0_0_0_0_00_0_1_000_1_0_0_0_0_0_0_0;
  localparam logic [19:0] E_SD   = 20'b0_0_0_0_1_10_0_0_001_0_0_0_0_0_1_0_0;
  localparam logic [19:0] E_BRT  = 20'b1_1_0_0_1_00_1_0_010_0_0_0_0_0_0_0_0;
  localparam logic [19:0] E_BRN  = 20'b0_1_0_0_1_00_0_0_010_0_0_0_0_0_0_0_0;
  localparam logic [19:0] E_NPC  = 20'b1_0_0_0_0_01_0_0_001_0_0_0_0_0_0_0_0;
  localparam logic [19:0] E_HB   = 20'b0_0_0_0_0_00_0_0_000_0_0_0_0_0_0_1_0;
  localparam logic [19:0] E_HI   = 20'b0_0_0_0_0_00_0_0_000_0_0_0_0_0_0_1_1;
  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_SUB  = 32'h403100B3;
  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LD   = 32'h0000B083;
  localparam logic [31:0] I_SD   = 32'h00007023;
  localparam logic [31:0] I_BEQ  = 32'h00000063;
  localparam logic [31:0] I_BNE  = 32'h00001067;
  localparam logic [31:0] I_BRK  = 32'h00100073;
  localparam logic [31:0] I_ILL  = 32'h0000007F;
  localparam logic [31:0] I_MUL  = 32'h023100B3;
  localparam logic [31:0] I_SLTI = 32'h00502093;
  localparam logic [31:0] I_RVBN = 32'h00001063;
  typedef struct {
    logic        r;
    logic [31:0] i;
    logic        z;
    logic        chk;
    logic [19:0] ctl;
    logic [31:0] cnt;
  } vec_t;
  vec_t tab[$];
  logic [31:0] ecnt;
  int tests = 0, fails = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic row(input logic r, input logic [31:0] i, input logic z, input logic [19:0] e);
    tab.push_back('{r, i, z, 1'b1, e, ecnt});
  endtask
  task automatic fetch(input logic [31:0] i);
    for (int j = 0; j < W; j++) row(1'b0, i, 1'b0, E_FET);
    row(1'b0, i, 1'b0, E_IR);
    row(1'b0, i, 1'b0, E_DEC);
  endtask
  task automatic npc(input logic [31:0] i);
    row(1'b0, i, 1'b0, E_NPC);
    ecnt++;
  endtask
  task automatic reset_from(input logic [31:0] i, input logic [19:0] e);
    row(1'b1, i, 1'b0, e);
    ecnt = 0;
    row(1'b0, i, 1'b0, E_RST);
  endtask
  task automatic halt_ill(input logic [31:0] i);
    fetch(i);
    for (int j = 0; j < 3; j++) row(1'b0, i, j[0], E_HI);
    reset_from(i, E_HI);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    rst = 1'b1;
    INSTR = '0;
    AluZero = 1'b0;
    ecnt = 0;
    tab.push_back('{1'b1, 32'h0, 1'b0, 1'b0, E_RST, 32'h0});
    row(1'b1, 32'h0, 1'b0, E_RST);
    row(1'b0, 32'h0, 1'b0, E_RST);
    fetch(I_ADD);  row(1'b0, I_ADD, 1'b0, E_ADD);   npc(I_ADD);
    fetch(I_SUB);  row(1'b0, I_SUB, 1'b0, E_SUB);   npc(I_SUB);
    fetch(I_ADDI); row(1'b0, I_ADDI, 1'b0, E_ADDI); npc(I_ADDI);
    fetch(I_LD);
    for (int j = 0; j < W; j++) row(1'b0, I_LD, 1'b0, E_LDA);
    row(1'b0, I_LD, 1'b0, E_LDC);
    row(1'b0, I_LD, 1'b0, E_LDW);
    npc(I_LD);
    fetch(I_SD);   row(1'b0, I_SD, 1'b0, E_SD);     npc(I_SD);
    fetch(I_BEQ);  row(1'b0, I_BEQ, 1'b1, E_BRT);   ecnt++;
    fetch(I_BEQ);  row(1'b0, I_BEQ, 1'b0, E_BRN);   npc(I_BEQ);
    fetch(I_BNE);  row(1'b0, I_BNE, 1'b0, E_BRT);   ecnt++;
    fetch(I_BNE);  row(1'b0, I_BNE, 1'b1, E_BRN);   npc(I_BNE);
    fetch(I_BRK);
    for (int j = 0; j < 20; j++) row(1'b0, I_BRK, j[0], E_HB);
    reset_from(I_BRK, E_HB);
    halt_ill(I_ILL);
    halt_ill(I_MUL);
    halt_ill(I_SLTI);
    halt_ill(I_RVBN);
    fetch(I_ADD);  row(1'b0, I_ADD, 1'b0, E_ADD);   npc(I_ADD);
    fetch(I_LD);
    reset_from(I_LD, E_LDA);
    row(1'b0, I_LD, 1'b0, E_FET);
    foreach (tab[k]) begin
      @(negedge clk);
      rst = tab[k].r;
      INSTR = tab[k].i;
      AluZero = tab[k].z;
      #1;
      if (tab[k].chk) begin
        check($sformatf("row%0d ctl", k), {12'h0, ctl}, {12'h0, tab[k].ctl});
        check($sformatf("row%0d instr_count", k), instr_count, tab[k].cnt);
      end
    end
    // branch outputs follow AluZero within the same cycle
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    INSTR = I_BEQ;
    AluZero = 1'b0;
    #1;
    for (n = 0; n < 20 && !PCWriteCond; n++) begin
      @(negedge clk);
      #1;
    end
    check("branch reached", {31'h0, PCWriteCond}, 32'h1);
    check("branch zero0 PCwrite", {31'h0, PCwrite}, 32'h0);
    AluZero = 1'b1;
    #1;
    check("branch zero1 PCwrite/SelMuxPC", {30'h0, PCwrite, SelMuxPC}, 32'h3);
    @(negedge clk);
    #1;
    check("taken branch refetch", {31'h0, MemRead}, 32'h1);
    check("taken branch count", instr_count, 32'h1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
Multicycle control FSM for the RV64I datapath. It consumes the instruction register word and the ALU zero flag. It drives every mux select, register load, memory write and PC enable of the datapath. It fetches, decodes and sequences add/sub/addi/ld/sd/beq/bne/break, halts on break or an illegal opcode, and counts retired instructions.

Parameters:
MEM_WAIT, 1, cycles the instruction or data memory needs between a stable address and valid read data (minimum 1).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset; one clock; reset is synchronous and active-high
INSTR  in  32  instruction register output; opcode [6:0], funct3 [14:12], funct7 [31:25]
AluZero  in  1  ALU zero flag, combinational from the current-cycle ALU setup
PCwrite  out  1  PC register load
PCWriteCond  out  1  high in the branch-evaluate state (status only)
MemRead  out  1  instruction fetch in progress
LoadIR  out  1  instruction register load
SelMux2  out  1  ALU A operand select: 0 = PC, 1 = A
SelMux4  out  2  ALU B operand select: 00 = B, 01 = 4, 10 = imm, 11 = imm<<1
SelMuxPC  out  1  PC source select: 0 = ALU result, 1 = AluOut
SelMuxMem  out  1  register writeback select: 0 = ALU result, 1 = MDR
AluOperation  out  3  ALU op: 001 = add, 010 = sub, 000 = default
RegWrite  out  1  register file write
loadRegA / loadRegB  out  1 each  operand register loads
loadRegAluOut  out  1  AluOut load
loadRegMemData  out  1  MDR load
MemData_Read  out  1  data memory write enable (1 = write)
exitState  out  1  high while halted
illegal_instr  out  1  high while halted due to an unsupported encoding
instr_count  out  32  retired instruction count

Behaviour:
- Output defaults: every output not listed for a state is 0.
- Outputs are Moore, except PCwrite and SelMuxPC in BRANCH, which depend on AluZero.
- wcnt: a wait counter, cleared on every state entry.
- rst (sampled on a clk edge): state <= RST_ST, wcnt <= 0, instr_count <= 0. Reset is honoured from any state, including mid-instruction or HALT.
- RST_ST: all outputs 0 -> FETCH.
- FETCH: MemRead=1. Stays MEM_WAIT cycles -> IR_LOAD.
- IR_LOAD: MemRead=1, LoadIR=1 -> DECODE.
- DECODE: loadRegA=1, loadRegB=1. SelMux2=0, SelMux4=11, add, loadRegAluOut=1, so AluOut <= PC + (imm<<1).
- DECODE dispatch on the opcode:
  - 0110011 with funct3 000 and funct7 0000000 or 0100000 -> EXEC_R.
  - 0010011 with funct3 000 -> EXEC_I.
  - 0000011 with funct3 011 -> LD_ADDR.
  - 0100011 with funct3 111 -> SD_WR.
  - 1100011 with funct3 000 (beq) -> BRANCH.
  - 1100111 with funct3 001 (bne) -> BRANCH.
  - 1110011 -> HALT, with illegal_instr=0.
  - Anything else -> HALT, with illegal_instr=1.
- EXEC_R: SelMux2=1, SelMux4=00. AluOperation is add when funct7 = 0, sub when funct7 = 0100000. RegWrite=1, SelMuxMem=0 -> NEXT_PC.
- EXEC_I: SelMux2=1, SelMux4=10, add, RegWrite=1, SelMuxMem=0 -> NEXT_PC.
- LD_ADDR: SelMux2=1, SelMux4=10, add. Holds MEM_WAIT cycles -> LD_CAP.
- LD_CAP: same ALU setup, loadRegMemData=1 -> LD_WB.
- LD_WB: RegWrite=1, SelMuxMem=1 -> NEXT_PC.
- SD_WR: SelMux2=1, SelMux4=10, add, MemData_Read=1 for exactly one cycle -> NEXT_PC.
- BRANCH: SelMux2=1, SelMux4=00, sub, PCWriteCond=1.
  - taken = beq ? AluZero : !AluZero.
  - Taken: PCwrite=1, SelMuxPC=1, instr_count += 1 -> FETCH.
  - Not taken -> NEXT_PC.
- NEXT_PC: SelMux2=0, SelMux4=01, add, SelMuxPC=0, PCwrite=1, instr_count += 1 -> FETCH.
- HALT: exitState=1, illegal_instr held. No further loads or writes. Left only by rst.
- instr_count wraps 0xFFFFFFFF -> 0 and does not count break or illegal instructions.
- Latency with MEM_WAIT = W:
  - R-type, addi, sd, not-taken branch: W+4 cycles.
  - Taken branch: W+3 cycles.
  - ld: 2W+5 cycles.
- x0 write suppression is the register file's responsibility, not this block's.

Test Plan:
1. rst high 2 cycles, then low -> all outputs 0 for RST_ST. MemRead=1 on the next cycle; LoadIR=1 exactly W cycles later; instr_count=0.
2. INSTR=0x003100B3 (add x1,x2,x3), W=1 -> RegWrite=1 with AluOperation=001 in cycle 4 after FETCH entry. PCwrite with SelMux4=01 in cycle 5; instr_count=1.
3. INSTR=0x0000B083 (ld), W=2 -> LD_ADDR held 2 cycles, loadRegMemData one cycle, RegWrite with SelMuxMem=1. Total 9 cycles; MemData_Read stays 0.
4. beq with AluZero=1 -> in BRANCH PCwrite=1, SelMuxPC=1, PCWriteCond=1, then FETCH. Same with AluZero=0 -> PCwrite=0 in BRANCH, then NEXT_PC.
5. INSTR=0x00100073 (break) -> exitState=1, illegal_instr=0, all writes 0 for 20 cycles. INSTR=0x0000007F -> exitState=1, illegal_instr=1.
6. rst asserted during LD_ADDR -> next state RST_ST, no RegWrite or loadRegMemData issued, instr_count=0.
